// File: rtl/mips_store_pkg.sv
// Shared definitions for the store narrowing path: size encodings, FSM states
// and the alignment rule used on request acceptance.
package mips_store_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    ERR
  } state_e;

  // Illegal size encodings are reported through the same path as misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = |offset;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational big-endian lane merge: writes the low byte/halfword of new_data
// into the selected lane of old_word, leaving other bytes untouched.
module store_merge
  import mips_store_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  output logic [31:0] merged_c
);

  always_comb begin
    merged_c = old_word;
    case (size)
      SZ_BYTE: begin
        case (offset)
          2'd0:    merged_c[31:24] = new_data[7:0];
          2'd1:    merged_c[23:16] = new_data[7:0];
          2'd2:    merged_c[15:8]  = new_data[7:0];
          default: merged_c[7:0]   = new_data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (offset[1]) merged_c[15:0]  = new_data[15:0];
        else           merged_c[31:16] = new_data[15:0];
      end
      default: merged_c = new_data;
    endcase
  end

endmodule

// File: rtl/store_narrow_rmw.sv
// Store narrowing unit: sub-word stores become read-modify-write on a
// word-only memory; word stores go straight to a write.
module store_narrow_rmw
  import mips_store_pkg::*;
#(
  parameter int unsigned ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data,
  output logic              done,
  output logic              misaligned
);

  state_e      state;
  state_e      state_d;
  logic        accept_c;
  logic [31:0] data_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [31:0] merged_c;

  store_merge u_merge (
    .old_word (mem_rd_data),
    .new_data (data_q),
    .size     (size_q),
    .offset   (off_q),
    .merged_c (merged_c)
  );

  // Next-state decode; requests are only looked at in IDLE.
  always_comb begin
    state_d  = state;
    accept_c = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
          if (is_misaligned(req_size, req_addr[1:0])) state_d = ERR;
          else if (req_size == SZ_WORD)                state_d = WRITE;
          else                                         state_d = READ;
        end
      end
      READ:    state_d = WAIT;
      WAIT:    state_d = WRITE;
      WRITE:   state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state, so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      done        <= 1'b0;
      misaligned  <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      data_q      <= '0;
      size_q      <= '0;
      off_q       <= '0;
    end else begin
      state      <= state_d;
      req_ready  <= (state_d == IDLE);
      mem_rd_en  <= (state_d == READ);
      mem_wr_en  <= (state_d == WRITE);
      done       <= (state_d == WRITE);
      misaligned <= (state_d == ERR);
      if (accept_c) begin
        mem_addr <= req_addr[ADDR_W+1:2];
        data_q   <= req_data;
        size_q   <= req_size;
        off_q    <= req_addr[1:0];
        if (state_d == WRITE) mem_wr_data <= req_data;
      end
      if (state == WAIT) mem_wr_data <= merged_c;
    end
  end

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Directed bench for store_narrow_rmw with a small word memory model.
module tb_store_narrow_rmw;
  import mips_store_pkg::*;

  localparam int unsigned ADDR_W = 30;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rd_data;
  logic              mem_wr_en;
  logic [31:0]       mem_wr_data;
  logic              done;
  logic              misaligned;

  store_narrow_rmw #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_size    (req_size),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .done        (done),
    .misaligned  (misaligned)
  );

  always #5 clk = ~clk;

  // Word memory: read data valid one cycle after the strobe.
  logic [31:0] mem [0:63];
  logic        pre_en;
  logic [5:0]  pre_addr;
  logic [31:0] pre_val;

  always @(posedge clk) begin
    if (pre_en)    mem[pre_addr] <= pre_val;
    if (mem_wr_en) mem[mem_addr[5:0]] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_addr[5:0]];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    int          kind;      // 0 sub-word, 1 word, 2 rejected
    logic [31:0] pre_val;
    logic [31:0] exp_waddr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [11];

  int          rd_cnt, wr_cnt, done_cnt, mis_cnt, overlap;
  int          rd_cyc, wr_cyc, wr2_cyc, done_cyc, mis_cyc, ready_cyc;
  logic [31:0] rd_addr, wr_addr, wr_data, wr2_addr, wr2_data;

  task automatic preload(input logic [5:0] a, input logic [31:0] v);
    @(negedge clk);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_val  = v;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
    chk({tag, " ready_before"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Samples cycles 1..ncyc after the accept edge, mid-cycle.
  task automatic observe(input int ncyc, input int drop_at);
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; mis_cnt = 0; overlap = 0;
    rd_cyc = 0; wr_cyc = 0; wr2_cyc = 0; done_cyc = 0; mis_cyc = 0; ready_cyc = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; wr2_addr = '0; wr2_data = '0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (mem_rd_en) begin
        rd_cnt++;
        rd_cyc  = c;
        rd_addr = 32'(mem_addr);
      end
      if (mem_wr_en) begin
        wr_cnt++;
        if (wr_cnt == 1) begin
          wr_cyc = c; wr_addr = 32'(mem_addr); wr_data = mem_wr_data;
        end else begin
          wr2_cyc = c; wr2_addr = 32'(mem_addr); wr2_data = mem_wr_data;
        end
      end
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (misaligned) begin
        mis_cnt++;
        mis_cyc = c;
      end
      if (mem_rd_en && mem_wr_en) overlap++;
      if (req_ready && ready_cyc == 0) ready_cyc = c;
      if (c == drop_at) req_valid = 1'b0;
    end
  endtask

  initial begin
    int bad;
    string t;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
    pre_en = 1'b0; pre_addr = '0; pre_val = '0;

    vecs[0]  = '{32'h05, 32'h0000_00AB, SZ_BYTE, 0, 32'h1122_3344, 32'd1,  32'h11AB_3344};
    vecs[1]  = '{32'h0A, 32'hFFFF_BEEF, SZ_HALF, 0, 32'h1122_3344, 32'd2,  32'h1122_BEEF};
    vecs[2]  = '{32'h0C, 32'hDEAD_BEEF, SZ_WORD, 1, 32'h0,         32'd3,  32'hDEAD_BEEF};
    vecs[3]  = '{32'h03, 32'h0000_1234, SZ_HALF, 2, 32'h0,         32'd0,  32'h0};
    vecs[4]  = '{32'h06, 32'h1234_5678, SZ_WORD, 2, 32'h0,         32'd0,  32'h0};
    vecs[5]  = '{32'h00, 32'h1234_5678, 2'b11,   2, 32'h0,         32'd0,  32'h0};
    vecs[6]  = '{32'h10, 32'h0000_0055, SZ_BYTE, 0, 32'hAABB_CCDD, 32'd4,  32'h55BB_CCDD};
    vecs[7]  = '{32'h17, 32'h1234_5699, SZ_BYTE, 0, 32'hAABB_CCDD, 32'd5,  32'hAABB_CC99};
    vecs[8]  = '{32'h18, 32'h0000_CAFE, SZ_HALF, 0, 32'h0123_4567, 32'd6,  32'hCAFE_4567};
    vecs[9]  = '{32'h1E, 32'h0000_00FF, SZ_BYTE, 0, 32'h0000_0000, 32'd7,  32'h0000_FF00};
    vecs[10] = '{32'h2C, 32'h0102_0304, SZ_WORD, 1, 32'h0,         32'd11, 32'h0102_0304};

    repeat (3) @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst strobes", {28'd0, mem_rd_en, mem_wr_en, done, misaligned}, 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst mem_wr_data", mem_wr_data, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      int exp_rdy;
      t = $sformatf("v%0d", i);
      if (vecs[i].kind != 2) preload(vecs[i].exp_waddr[5:0], vecs[i].pre_val);
      issue(t, vecs[i].addr, vecs[i].data, vecs[i].size);
      observe(6, 0);
      exp_rdy = (vecs[i].kind == 0) ? 4 : 2;
      chk({t, " rd_cnt"},   32'(rd_cnt),   (vecs[i].kind == 0) ? 32'd1 : 32'd0);
      chk({t, " wr_cnt"},   32'(wr_cnt),   (vecs[i].kind != 2) ? 32'd1 : 32'd0);
      chk({t, " done_cnt"}, 32'(done_cnt), (vecs[i].kind != 2) ? 32'd1 : 32'd0);
      chk({t, " mis_cnt"},  32'(mis_cnt),  (vecs[i].kind == 2) ? 32'd1 : 32'd0);
      chk({t, " ready_cyc"}, 32'(ready_cyc), 32'(exp_rdy));
      chk({t, " overlap"},  32'(overlap),  32'd0);
      if (vecs[i].kind == 0) begin
        chk({t, " rd_cyc"},  32'(rd_cyc), 32'd1);
        chk({t, " rd_addr"}, rd_addr, vecs[i].exp_waddr);
      end
      if (vecs[i].kind != 2) begin
        chk({t, " wr_cyc"},   32'(wr_cyc),   (vecs[i].kind == 0) ? 32'd3 : 32'd1);
        chk({t, " done_cyc"}, 32'(done_cyc), (vecs[i].kind == 0) ? 32'd3 : 32'd1);
        chk({t, " wr_addr"},  wr_addr, vecs[i].exp_waddr);
        chk({t, " wr_data"},  wr_data, vecs[i].exp_wdata);
        chk({t, " mem"},      mem[vecs[i].exp_waddr[5:0]], vecs[i].exp_wdata);
      end else begin
        chk({t, " mis_cyc"}, 32'(mis_cyc), 32'd1);
      end
    end

    // Reset while waiting on read data of a byte store.
    preload(6'd4, 32'hCAFE_F00D);
    issue("rstmid", 32'h10, 32'h0000_0099, SZ_BYTE);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid strobes", {28'd0, mem_rd_en, mem_wr_en, done, misaligned}, 32'd0);
    chk("rstmid mem_addr", 32'(mem_addr), 32'd0);
    chk("rstmid mem_wr_data", mem_wr_data, 32'd0);
    chk("rstmid req_ready", 32'(req_ready), 32'd1);
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (mem_wr_en || !req_ready) bad++;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (mem_wr_en || mem_rd_en || !req_ready) bad++;
    end
    chk("rstmid no_write", 32'(bad), 32'd0);
    chk("rstmid mem", mem[4], 32'hCAFE_F00D);

    // Back-to-back with req_valid held: byte then word.
    preload(6'd8, 32'h1122_3344);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h20;
    req_data  = 32'h0000_0077;
    req_size  = SZ_BYTE;
    @(posedge clk);
    #1;
    req_addr  = 32'h24;
    req_data  = 32'h5A5A_5A5A;
    req_size  = SZ_WORD;
    observe(7, 5);
    chk("b2b rd_cnt",   32'(rd_cnt),   32'd1);
    chk("b2b wr_cnt",   32'(wr_cnt),   32'd2);
    chk("b2b done_cnt", 32'(done_cnt), 32'd2);
    chk("b2b wr_cyc",   32'(wr_cyc),   32'd3);
    chk("b2b wr_addr",  wr_addr,  32'd8);
    chk("b2b wr_data",  wr_data,  32'h7722_3344);
    chk("b2b ready_cyc", 32'(ready_cyc), 32'd4);
    chk("b2b wr2_cyc",  32'(wr2_cyc),  32'd5);
    chk("b2b wr2_addr", wr2_addr, 32'd9);
    chk("b2b wr2_data", wr2_data, 32'h5A5A_5A5A);
    chk("b2b overlap",  32'(overlap),  32'd0);
    chk("b2b mem8",     mem[8], 32'h7722_3344);
    chk("b2b mem9",     mem[9], 32'h5A5A_5A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
